// File: rtl/param_code_lock.sv
// -----------------------------------------------------------------------------
// param_code_lock
//
// Multi-digit code lock. Digits arrive one per digit_valid pulse from a
// debounced keypad front-end. A complete entry is compared against a stored,
// reprogrammable code. A correct code opens the lock for a bounded time. Wrong
// codes are counted, and enough consecutive failures start a timed lockout
// during which all input is ignored. While open, the code can be replaced.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset (restores DEFAULT_CODE)
//   digit_valid  one digit presented this cycle
//   digit        digit value, sampled only with digit_valid
//   clear        abort entry/programming, or relock early while open
//   prog_en      request code reprogramming, honoured only while open
//   unlocked     lock open (registered)
//   locked_out   lockout active, input ignored (registered)
//   error        one-cycle pulse on a wrong complete code
//   prog_done    one-cycle pulse when a new code is committed
//   fail_cnt     current consecutive-failure count
// -----------------------------------------------------------------------------
module param_code_lock #(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int OPEN_CYC    = 8,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           clear,
    input  logic                           prog_en,
    output logic                           unlocked,
    output logic                           locked_out,
    output logic                           error,
    output logic                           prog_done,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int IDX_W   = $clog2(CODE_LEN);
    localparam int FC_W    = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [FC_W-1:0]  FAIL_LIMIT = FC_W'(MAX_FAILS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    state_t              state_reg;
    logic [CODE_W-1:0]   code_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic [FC_W-1:0]     fail_cnt_reg;
    logic                pending_reg;   // full entry captured, verdict next edge
    logic                match_reg;     // verdict of the captured entry
    logic                unlocked_reg;
    logic                locked_out_reg;
    logic                error_reg;
    logic                prog_done_reg;

    // The first CODE_LEN-1 digits of an entry (or of a new code while
    // programming) are held here; the last digit is never stored because it
    // is consumed directly from the bus in the cycle it arrives. Entry and
    // programming are mutually exclusive, so one buffer serves as both the
    // entry register and the programming staging register.
    logic [DIGIT_W-1:0]  digit_buf_reg [CODE_LEN-1];

    logic                buf_wr;        // current digit goes into the buffer
    logic [CODE_W-1:0]   cand_code;     // buffered digits + digit on the bus
    logic                cand_match;

    // -------------------------------------------------------------------------
    // Candidate code: buffered digits followed by the digit on the bus. The
    // first-entered digit lands in the most significant position.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CODE_LEN - 1; gi++) begin : g_cand
            assign cand_code[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W] = digit_buf_reg[gi];
        end
    endgenerate

    assign cand_code[DIGIT_W-1:0] = digit;
    assign cand_match             = (cand_code == code_reg);

    // -------------------------------------------------------------------------
    // Buffer write enable. In IDLE the index is always 0 (every exit from
    // ENTRY/PROG resets it), so the first digit of an entry goes to slot 0.
    // The final digit of an entry or code is not buffered.
    // -------------------------------------------------------------------------
    always_comb begin
        buf_wr = 1'b0;
        case (state_reg)
            ST_IDLE:  buf_wr = digit_valid && !clear;
            ST_ENTRY: buf_wr = digit_valid && !clear && !pending_reg && (idx_reg != IDX_LAST);
            ST_PROG:  buf_wr = digit_valid && !clear && (idx_reg != IDX_LAST);
            default:  buf_wr = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < CODE_LEN - 1; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_buf_reg[gi] <= '0;
                end else if (buf_wr && (idx_reg == IDX_W'(gi))) begin
                    digit_buf_reg[gi] <= digit;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            code_reg       <= DEFAULT_CODE;
            idx_reg        <= '0;
            timer_reg      <= '0;
            fail_cnt_reg   <= '0;
            pending_reg    <= 1'b0;
            match_reg      <= 1'b0;
            unlocked_reg   <= 1'b0;
            locked_out_reg <= 1'b0;
            error_reg      <= 1'b0;
            prog_done_reg  <= 1'b0;
        end else begin
            // Pulsed outputs fall back to 0 unless set below.
            error_reg     <= 1'b0;
            prog_done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // clear beats digit_valid; CODE_LEN >= 2 so a single
                    // digit can never complete a code here.
                    if (digit_valid && !clear) begin
                        idx_reg   <= IDX_W'(1);
                        state_reg <= ST_ENTRY;
                    end
                end

                ST_ENTRY: begin
                    if (pending_reg) begin
                        // The complete entry was captured on the previous
                        // edge; its verdict becomes visible on this one.
                        // Bus input is ignored during this single cycle.
                        pending_reg <= 1'b0;
                        idx_reg     <= '0;
                        if (match_reg) begin
                            state_reg    <= ST_OPEN;
                            unlocked_reg <= 1'b1;
                            fail_cnt_reg <= '0;
                            timer_reg    <= '0;
                        end else if ((fail_cnt_reg + FC_W'(1)) < FAIL_LIMIT) begin
                            state_reg    <= ST_IDLE;
                            error_reg    <= 1'b1;
                            fail_cnt_reg <= fail_cnt_reg + FC_W'(1);
                        end else begin
                            state_reg      <= ST_LOCKOUT;
                            error_reg      <= 1'b1;
                            fail_cnt_reg   <= FAIL_LIMIT;
                            locked_out_reg <= 1'b1;
                            timer_reg      <= '0;
                        end
                    end else if (clear) begin
                        // Abandon the partial entry; not counted as a failure.
                        state_reg <= ST_IDLE;
                        idx_reg   <= '0;
                    end else if (digit_valid) begin
                        if (idx_reg == IDX_LAST) begin
                            match_reg   <= cand_match;
                            pending_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end

                ST_OPEN: begin
                    // digit_valid is ignored while open.
                    if (clear) begin
                        state_reg    <= ST_IDLE;
                        unlocked_reg <= 1'b0;
                    end else if (prog_en) begin
                        state_reg    <= ST_PROG;
                        unlocked_reg <= 1'b0;
                        idx_reg      <= '0;
                    end else if (timer_reg == OPEN_LAST) begin
                        state_reg    <= ST_IDLE;
                        unlocked_reg <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end

                ST_PROG: begin
                    // code_reg only changes at commit, so an aborted
                    // programming session keeps the previous code.
                    if (clear) begin
                        state_reg <= ST_IDLE;
                        idx_reg   <= '0;
                    end else if (digit_valid) begin
                        if (idx_reg == IDX_LAST) begin
                            code_reg      <= cand_code;
                            prog_done_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                            idx_reg       <= '0;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end

                ST_LOCKOUT: begin
                    // All inputs are ignored until the lockout period ends.
                    if (timer_reg == LOCK_LAST) begin
                        state_reg      <= ST_IDLE;
                        locked_out_reg <= 1'b0;
                        fail_cnt_reg   <= '0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    idx_reg        <= '0;
                    pending_reg    <= 1'b0;
                    unlocked_reg   <= 1'b0;
                    locked_out_reg <= 1'b0;
                end
            endcase
        end
    end

    assign unlocked   = unlocked_reg;
    assign locked_out = locked_out_reg;
    assign error      = error_reg;
    assign prog_done  = prog_done_reg;
    assign fail_cnt   = fail_cnt_reg;

endmodule

// File: tb/tb_param_code_lock.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_param_code_lock
//
// Scoreboard bench. The driver applies one cycle of input at a time and, for
// each cycle, advances a behavioural model that keeps the entered digits in
// queues and tracks open/lockout windows as absolute cycle numbers. The model
// pushes the output events it expects (error/prog_done pulses, unlocked and
// locked_out edges, each with the cycle it appears and the fail count then)
// into a queue. An independent monitor watches the DUT outputs and pops and
// compares one expected event for every event it observes.
// -----------------------------------------------------------------------------
module tb_param_code_lock;

    localparam int DW  = 4;
    localparam int CL  = 4;
    localparam int MF  = 3;
    localparam int LC  = 16;
    localparam int OC  = 8;
    localparam int FCW = $clog2(MF + 1);
    localparam logic [CL*DW-1:0] DEF_CODE = 16'h1234;

    localparam int K_ERR    = 0;
    localparam int K_PROG   = 1;
    localparam int K_OPEN   = 2;
    localparam int K_CLOSE  = 3;
    localparam int K_LOCK   = 4;
    localparam int K_UNLOCK = 5;

    localparam int M_IDLE   = 0;
    localparam int M_ENTRY  = 1;
    localparam int M_DECIDE = 2;
    localparam int M_OPEN   = 3;
    localparam int M_PROG   = 4;
    localparam int M_LOCK   = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           digit_valid = 1'b0;
    logic [DW-1:0]  digit = '0;
    logic           clear = 1'b0;
    logic           prog_en = 1'b0;
    logic           unlocked;
    logic           locked_out;
    logic           error;
    logic           prog_done;
    logic [FCW-1:0] fail_cnt;

    param_code_lock #(
        .DIGIT_W     (DW),
        .CODE_LEN    (CL),
        .MAX_FAILS   (MF),
        .LOCKOUT_CYC (LC),
        .OPEN_CYC    (OC),
        .DEFAULT_CODE(DEF_CODE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_valid(digit_valid),
        .digit      (digit),
        .clear      (clear),
        .prog_en    (prog_en),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .error      (error),
        .prog_done  (prog_done),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int cyc;
        int fc;
    } ev_t;

    ev_t exp_q[$];

    function automatic string kname(input int k);
        case (k)
            K_ERR:    return "error";
            K_PROG:   return "prog_done";
            K_OPEN:   return "unlocked_rise";
            K_CLOSE:  return "unlocked_fall";
            K_LOCK:   return "locked_out_rise";
            K_UNLOCK: return "locked_out_fall";
            default:  return "unknown";
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int            m_mode;
    int            m_fail;
    int            m_open_end;
    int            m_lock_end;
    bit            m_ok;
    logic [DW-1:0] m_code [CL];
    logic [DW-1:0] m_entry[$];

    function automatic void push_ev(input int k, input int c, input int f);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.fc   = f;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        logic [CL*DW-1:0] dc;
        dc = DEF_CODE;
        for (int i = 0; i < CL; i++) m_code[i] = dc[(CL-1-i)*DW +: DW];
        m_entry.delete();
        m_mode = M_IDLE;
        m_fail = 0;
    endfunction

    function automatic logic [CL*DW-1:0] model_code_vec();
        logic [CL*DW-1:0] v;
        v = '0;
        for (int i = 0; i < CL; i++) v[(CL-1-i)*DW +: DW] = m_code[i];
        return v;
    endfunction

    // Inputs applied for clock edge e; events are stamped with the edge after
    // which they become visible.
    function automatic void model_step(input int e, input bit dv, input logic [DW-1:0] d,
                                       input bit clr, input bit pe, input bit rs);
        if (rs) begin
            if (m_mode == M_OPEN) push_ev(K_CLOSE, e, 0);
            if (m_mode == M_LOCK) push_ev(K_UNLOCK, e, 0);
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (dv && !clr) begin
                    m_entry.delete();
                    m_entry.push_back(d);
                    m_mode = M_ENTRY;
                end
            end
            M_ENTRY: begin
                if (clr) begin
                    m_entry.delete();
                    m_mode = M_IDLE;
                end else if (dv) begin
                    m_entry.push_back(d);
                    if (m_entry.size() == CL) begin
                        m_ok = 1'b1;
                        for (int i = 0; i < CL; i++)
                            if (m_entry[i] != m_code[i]) m_ok = 1'b0;
                        m_mode = M_DECIDE;
                    end
                end
            end
            M_DECIDE: begin
                m_entry.delete();
                if (m_ok) begin
                    m_fail     = 0;
                    m_open_end = e + OC;
                    m_mode     = M_OPEN;
                    push_ev(K_OPEN, e, 0);
                end else begin
                    m_fail = m_fail + 1;
                    push_ev(K_ERR, e, m_fail);
                    if (m_fail == MF) begin
                        push_ev(K_LOCK, e, m_fail);
                        m_lock_end = e + LC;
                        m_mode     = M_LOCK;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_OPEN: begin
                if (clr) begin
                    push_ev(K_CLOSE, e, m_fail);
                    m_mode = M_IDLE;
                end else if (pe) begin
                    push_ev(K_CLOSE, e, m_fail);
                    m_entry.delete();
                    m_mode = M_PROG;
                end else if (e == m_open_end) begin
                    push_ev(K_CLOSE, e, m_fail);
                    m_mode = M_IDLE;
                end
            end
            M_PROG: begin
                if (clr) begin
                    m_entry.delete();
                    m_mode = M_IDLE;
                end else if (dv) begin
                    m_entry.push_back(d);
                    if (m_entry.size() == CL) begin
                        for (int i = 0; i < CL; i++) m_code[i] = m_entry[i];
                        m_entry.delete();
                        push_ev(K_PROG, e, m_fail);
                        m_mode = M_IDLE;
                    end
                end
            end
            M_LOCK: begin
                if (e == m_lock_end) begin
                    m_fail = 0;
                    push_ev(K_UNLOCK, e, 0);
                    m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit mon_en   = 1'b0;
    bit prev_unl = 1'b0;
    bit prev_lo  = 1'b0;

    task automatic observe(input int kind, input int fc);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d fail_cnt %0d, expected no event",
                     kname(kind), cyc, fc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.fc != fc) begin
                errors++;
                $display("FAIL event: got %s at cycle %0d fail_cnt %0d, expected %s at cycle %0d fail_cnt %0d",
                         kname(kind), cyc, fc, kname(e.kind), e.cyc, e.fc);
            end else begin
                $display("event %s cycle %0d fail_cnt %0d ok", kname(kind), cyc, fc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (error === 1'b1)                  observe(K_ERR, int'(fail_cnt));
            if (prog_done === 1'b1)              observe(K_PROG, int'(fail_cnt));
            if (unlocked === 1'b1 && !prev_unl)  observe(K_OPEN, int'(fail_cnt));
            if (unlocked !== 1'b1 && prev_unl)   observe(K_CLOSE, int'(fail_cnt));
            if (locked_out === 1'b1 && !prev_lo) observe(K_LOCK, int'(fail_cnt));
            if (locked_out !== 1'b1 && prev_lo)  observe(K_UNLOCK, int'(fail_cnt));
            prev_unl = (unlocked === 1'b1);
            prev_lo  = (locked_out === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic tick(input bit dv, input logic [DW-1:0] d, input bit clr,
                        input bit pe, input bit rs);
        digit_valid = dv;
        digit       = d;
        clear       = clr;
        prog_en     = pe;
        rst         = rs;
        model_step(cyc + 1, dv, d, clr, pe, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [CL*DW-1:0] c, input int gap);
        for (int i = 0; i < CL; i++) begin
            tick(1'b1, c[(CL-1-i)*DW +: DW], 1'b0, 1'b0, 1'b0);
            idle(gap);
        end
    endtask

    task automatic enter_code_rg(input logic [CL*DW-1:0] c);
        for (int i = 0; i < CL; i++) begin
            tick(1'b1, c[(CL-1-i)*DW +: DW], 1'b0, 1'b0, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({unlocked, locked_out, error, prog_done} !== 4'b0000) begin
            errors++;
            $display("FAIL %s outputs: got unl=%b lo=%b err=%b pd=%b, expected all 0",
                     name, unlocked, locked_out, error, prog_done);
        end else begin
            $display("check %s outputs all 0 ok", name);
        end
        checks++;
        if (fail_cnt !== '0) begin
            errors++;
            $display("FAIL %s fail_cnt: got %0d, expected 0", name, fail_cnt);
        end else begin
            $display("check %s fail_cnt 0 ok", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_zero("reset");
        mon_en = 1'b1;

        // 1: correct code with gaps, open window then close
        enter_code(16'h1234, 1);
        idle(OC + 4);

        // 2: one wrong code, then correct code clears the count
        enter_code(16'h1235, 1);
        idle(3);
        enter_code(16'h1234, 0);
        idle(OC + 4);

        // 3: three wrong codes -> lockout, entry ignored inside lockout
        for (int k = 0; k < MF; k++) begin
            enter_code(16'h9999, 0);
            idle(2);
        end
        enter_code(16'h1234, 0);
        idle(LC + 2);
        enter_code(16'h1234, 0);
        idle(OC + 4);

        // 4: reprogram to ABCD, old code fails, new opens, rst restores default
        enter_code(16'h1234, 0);
        idle(2);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        enter_code(16'hABCD, 0);
        idle(2);
        enter_code(16'h1234, 0);
        idle(3);
        enter_code(16'hABCD, 0);
        idle(OC + 4);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        enter_code(16'h1234, 0);
        idle(OC + 4);

        // 5: clear beats the third digit, no failure counted
        tick(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        idle(2);
        enter_code(16'h1234, 0);
        idle(OC + 4);

        // 6: early relock by clear, then rst while open
        enter_code(16'h1234, 0);
        idle(3);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(3);
        enter_code(16'h1234, 0);
        idle(3);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_zero("rst_in_open");
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: enter_code_rg(model_code_vec());
                3, 4: begin
                    logic [CL*DW-1:0] rc;
                    rc = (CL*DW)'($urandom);
                    enter_code_rg(rc);
                end
                5: begin
                    int np;
                    np = int'($urandom_range(1, CL - 1));
                    for (int i = 0; i < np; i++)
                        tick(1'b1, DW'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
                    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
                end
                6, 7, 8: begin
                    int nc;
                    nc = int'($urandom_range(1, 6));
                    for (int i = 0; i < nc; i++)
                        tick(($urandom_range(0, 1) == 1), DW'($urandom_range(0, 15)),
                             ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0), 1'b0);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
                    else idle(OC + 2);
                end
            endcase
        end

        idle(LC + OC + 6);
        mon_en = 1'b0;

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing, expected %s at cycle %0d fail_cnt %0d",
                     kname(e.kind), e.cyc, e.fc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_code_lock.md
Name: param_code_lock

Overview:
Parametrised successor to the single-bit sequence lock. It accepts a multi-digit code over a valid-qualified digit bus and compares it against a stored, reprogrammable code. A correct code holds `unlocked` for a bounded number of cycles. Consecutive failures are counted and trigger a timed lockout. The block sits between a keypad front-end (debounced, one `digit_valid` pulse per key) and the actuator/status logic.

Parameters:
- DIGIT_W, 4, width of one entered digit.
- CODE_LEN, 4, digits per code (>=2).
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout (>=1).
- LOCKOUT_CYC, 16, cycles spent in lockout (>=1).
- OPEN_CYC, 8, cycles `unlocked` stays high (>=1).
- DEFAULT_CODE, 16'h1234, code loaded at reset; width CODE_LEN*DIGIT_W; first-entered digit is the MS digit.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- digit_valid, in, 1, one digit presented this cycle.
- digit, in, DIGIT_W, digit value; sampled only when digit_valid=1.
- clear, in, 1, abort entry/programming, or relock.
- prog_en, in, 1, request code reprogramming; honoured only in OPEN.
- unlocked, out, 1, lock open.
- locked_out, out, 1, lockout active; input ignored.
- error, out, 1, one-cycle pulse on a wrong complete code.
- prog_done, out, 1, one-cycle pulse when a new code is committed.
- fail_cnt, out, $clog2(MAX_FAILS+1), current consecutive-failure count.

Behaviour:
- Reset:
  - state=IDLE; code register=DEFAULT_CODE; digit index=0; timers=0.
  - All outputs 0.
  - Any reprogrammed code is lost.
- Outputs are registered (Moore) and change only on clk edges.
- States: IDLE, ENTRY, OPEN, PROG, LOCKOUT.
- IDLE:
  - digit_valid -> store digit at index 0, index=1, go to ENTRY.
  - CODE_LEN is >=2, so one digit never completes a code.
- ENTRY:
  - Each digit_valid stores a digit and increments the index.
  - When the CODE_LEN-th digit is accepted, compare the full entry with the code register in that same cycle.
  - Match -> next cycle: OPEN, unlocked=1, fail_cnt=0.
  - Mismatch with fail_cnt+1 < MAX_FAILS -> fail_cnt++, error pulses one cycle, go to IDLE.
  - Mismatch with fail_cnt+1 == MAX_FAILS -> error pulses, fail_cnt=MAX_FAILS, go to LOCKOUT, locked_out=1 from the next cycle.
  - Latency: last digit accepted at edge N -> unlocked/error/locked_out visible after edge N+1.
- OPEN:
  - unlocked=1 for exactly OPEN_CYC cycles, then IDLE with unlocked=0.
  - digit_valid is ignored.
  - clear -> IDLE next cycle (early relock).
  - prog_en (and no clear) -> PROG, unlocked=0, index=0.
- PROG:
  - CODE_LEN digits go into a staging register.
  - On the last digit: code register = staging, prog_done pulses, go to IDLE.
  - The code register is untouched until commit.
  - clear or rst mid-PROG leaves the old code (rst: DEFAULT_CODE) in place.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYC cycles.
  - digit_valid, clear and prog_en are ignored.
  - Exit to IDLE with fail_cnt=0 and locked_out=0.
- clear in ENTRY: discard the partial entry, go to IDLE, no failure counted, no error pulse.
- Simultaneous events:
  - clear beats digit_valid and prog_en in the same cycle.
  - rst beats everything.
- Wrap-around:
  - The index never exceeds CODE_LEN-1; it resets to 0 on every exit from ENTRY/PROG.
  - Timers saturate at their terminal count, then reload on state entry.
- fail_cnt:
  - Cleared only by success, LOCKOUT exit, or rst.
  - Persists across clear and across OPEN timeout.

Test Plan:
1. After rst, enter 1,2,3,4 with single-cycle gaps -> unlocked=1 one cycle after the '4' edge, held 8 cycles, then 0; fail_cnt=0.
2. Enter 1,2,3,5 -> error pulses one cycle, fail_cnt=1, unlocked stays 0. Then enter 1,2,3,4 -> opens and fail_cnt=0.
3. Three wrong codes (9,9,9,9 x3) -> fail_cnt=3, locked_out=1 for 16 cycles. Entering 1,2,3,4 during lockout has no effect. After lockout, fail_cnt=0 and 1,2,3,4 opens.
4. Open, assert prog_en, enter A,B,C,D -> prog_done pulses. Then 1,2,3,4 gives error and A,B,C,D opens. Apply rst -> 1,2,3,4 opens again.
5. Enter 1,2 then clear in the same cycle as digit_valid='3' -> IDLE, no error, fail_cnt unchanged. Following 1,2,3,4 opens.
6. Open, then clear at cycle 3 of OPEN -> unlocked=0 next cycle. Open again with rst asserted in OPEN -> unlocked=0 next cycle, all outputs 0.
